// File: rtl/pc_seq_pkg.sv
// Shared constants for the program-counter sequencer: next-PC select encodings,
// reset/step defaults and the jump-region split position.
package pc_seq_pkg;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PC_SRC_SEQ    = 2'b00;
  localparam pc_src_t PC_SRC_BRANCH = 2'b01;
  localparam pc_src_t PC_SRC_JUMP   = 2'b10;
  localparam pc_src_t PC_SRC_REG    = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int unsigned DEFAULT_STEP     = 4;

  // J-type targets keep PC bits above this position from pc + STEP.
  localparam int unsigned JUMP_SPLIT = 28;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-FSM <-> PC sequencer signal bundle. The master modport is the control side;
// the slave modport is the sequencer.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 32
);
  logic                   pc_write;
  pc_src_t                pc_src;
  logic                   branch_cond;
  logic [WORD_LENGTH-1:0] sign_ext_imm;
  logic [25:0]            jump_index;
  logic [WORD_LENGTH-1:0] reg_target;
  logic                   link;
  logic                   ret;
  logic [WORD_LENGTH-1:0] pc;
  logic [WORD_LENGTH-1:0] pc_plus_step;
  logic [WORD_LENGTH-1:0] branch_target;
  logic                   ras_full;
  logic                   ras_empty;
  logic                   misaligned;

  modport master (
    output pc_write, pc_src, branch_cond, sign_ext_imm, jump_index, reg_target, link, ret,
    input  pc, pc_plus_step, branch_target, ras_full, ras_empty, misaligned
  );

  modport slave (
    input  pc_write, pc_src, branch_cond, sign_ext_imm, jump_index, reg_target, link, ret,
    output pc, pc_plus_step, branch_target, ras_full, ras_empty, misaligned
  );

endinterface

// File: rtl/return_stack.sv
// Circular return-address stack with saturating occupancy count. When full, a push
// overwrites the oldest entry; push and pop together replace the top in place.
module return_stack #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WORD_LENGTH-1:0] push_data,
  output logic [WORD_LENGTH-1:0] top,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WORD_LENGTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]        top_q, top_d, wr_ptr;
  logic [CntW-1:0]        count_q, count_d;
  logic                   pop_ok, wr_en;

  assign full   = (count_q == CntW'(RAS_DEPTH));
  assign empty  = (count_q == '0);
  assign top    = mem_q[top_q];
  // A pop on an empty stack is a no-op; the caller falls back to the register target.
  assign pop_ok = pop & ~empty;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q;
    if (push && pop_ok) begin
      wr_en = 1'b1;
    end else if (push) begin
      top_d  = top_q + 1'b1;
      wr_ptr = top_d;
      wr_en  = 1'b1;
      if (!full) begin
        count_d = count_q + 1'b1;
      end
    end else if (pop_ok) begin
      top_d   = top_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle MIPS PC register with sequential/branch/jump/register next-PC selection.
// Define PC_SEQUENCER_RAS_EN to build in the return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned            WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = WORD_LENGTH'(DEFAULT_RESET_PC),
  parameter int unsigned            STEP        = DEFAULT_STEP,
  parameter int unsigned            RAS_DEPTH   = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic [WORD_LENGTH-1:0] pc_plus_step, branch_target, jump_target, ras_top;
  logic                   misaligned_q;
  logic                   ras_hit, ras_full, ras_empty;

  assign pc_plus_step  = pc_q + WORD_LENGTH'(STEP);
  assign branch_target = pc_plus_step + (bus.sign_ext_imm << 2);
  assign jump_target   = {pc_plus_step[WORD_LENGTH-1:JUMP_SPLIT], bus.jump_index, 2'b00};

`ifdef PC_SEQUENCER_RAS_EN
  logic ras_push, ras_pop;

  assign ras_push = bus.pc_write & bus.link;
  assign ras_pop  = bus.pc_write & (bus.pc_src == PC_SRC_REG) & bus.ret;
  assign ras_hit  = bus.ret & ~ras_empty;

  return_stack #(
    .WORD_LENGTH (WORD_LENGTH),
    .RAS_DEPTH   (RAS_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_step),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`else
  logic                     unused_ras_ctrl;
  logic [$clog2(RAS_DEPTH):0] unused_ras_depth;

  assign unused_ras_ctrl  = bus.link ^ bus.ret;
  assign unused_ras_depth = '0;
  assign ras_hit          = 1'b0;
  assign ras_top          = '0;
  assign ras_full         = 1'b0;
  assign ras_empty        = 1'b1;
`endif

  always_comb begin
    pc_d = pc_plus_step;
    case (bus.pc_src)
      PC_SRC_SEQ:    pc_d = pc_plus_step;
      PC_SRC_BRANCH: pc_d = bus.branch_cond ? branch_target : pc_plus_step;
      PC_SRC_JUMP:   pc_d = jump_target;
      PC_SRC_REG:    pc_d = ras_hit ? ras_top : bus.reg_target;
    endcase
  end

  // Unaligned targets still load; misaligned just flags them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else if (bus.pc_write) begin
      pc_q         <= pc_d;
      misaligned_q <= |pc_d[1:0];
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus_step  = pc_plus_step;
  assign bus.branch_target = branch_target;
  assign bus.ras_full      = ras_full;
  assign bus.ras_empty     = ras_empty;
  assign bus.misaligned    = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PC/flags are queued as each step is driven
// and checked after the loading edge. Expectations follow PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit Ras = 1'b1;
`else
  localparam bit Ras = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        mis;
    logic        chk;
    logic        full;
    logic        empty;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  pc_sequencer_if #(.WORD_LENGTH(32)) bus ();

  pc_sequencer #(
    .WORD_LENGTH (32),
    .RESET_PC    (32'h0040_0000),
    .STEP        (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %h required %h", tag, got, want);
    end
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".pc"}, bus.pc, e.pc);
    cmp({e.tag, ".misaligned"}, 32'(bus.misaligned), 32'(e.mis));
    if (e.chk) begin
      cmp({e.tag, ".ras_full"}, 32'(bus.ras_full), 32'(e.full));
      cmp({e.tag, ".ras_empty"}, 32'(bus.ras_empty), 32'(e.empty));
    end
  endtask

  task automatic step(input string tag, input logic w, input pc_src_t src, input logic cond,
                      input logic [31:0] imm, input logic [25:0] jidx, input logic [31:0] rtgt,
                      input logic lnk, input logic rt, input logic [31:0] exp_pc,
                      input logic exp_mis, input logic chk, input logic exp_full,
                      input logic exp_empty);
    @(negedge clk);
    bus.pc_write     = w;
    bus.pc_src       = src;
    bus.branch_cond  = cond;
    bus.sign_ext_imm = imm;
    bus.jump_index   = jidx;
    bus.reg_target   = rtgt;
    bus.link         = lnk;
    bus.ret          = rt;
    sb.push_back('{tag, exp_pc, exp_mis, chk, exp_full, exp_empty});
    @(posedge clk);
    #1;
    check_front();
    bus.pc_write = 1'b0;
    bus.link     = 1'b0;
    bus.ret      = 1'b0;
  endtask

  // Register-target load with no stack activity.
  task automatic ld(input string tag, input logic [31:0] tgt, input logic mis);
    step(tag, 1'b1, PC_SRC_REG, 1'b0, 32'h0, 26'h0, tgt, 1'b0, 1'b0, tgt, mis, 1'b0, 1'b0,
         1'b0);
  endtask

  task automatic seq(input string tag, input logic [31:0] exp_pc, input logic mis);
    step(tag, 1'b1, PC_SRC_SEQ, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, exp_pc, mis, 1'b0,
         1'b0, 1'b0);
  endtask

  // Stack-related step on pc_src=11 with flag checks.
  task automatic rs(input string tag, input logic w, input logic lnk, input logic rt,
                    input logic [31:0] rtgt, input logic [31:0] exp_pc, input logic exp_full,
                    input logic exp_empty);
    step(tag, w, PC_SRC_REG, 1'b0, 32'h0, 26'h0, rtgt, lnk, rt, exp_pc, 1'b0, 1'b1, exp_full,
         exp_empty);
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    reset            = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_SRC_SEQ;
    bus.branch_cond  = 1'b0;
    bus.sign_ext_imm = '0;
    bus.jump_index   = '0;
    bus.reg_target   = '0;
    bus.link         = 1'b0;
    bus.ret          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{"reset", 32'h0040_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    check_front();
    cmp("reset.pc_plus_step", bus.pc_plus_step, 32'h0040_0004);
    @(negedge clk);
    reset = 1'b1;

    seq("seq1", 32'h0040_0004, 1'b0);
    seq("seq2", 32'h0040_0008, 1'b0);
    seq("seq3", 32'h0040_000C, 1'b0);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    sb.push_back('{"midreset", 32'h0040_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    check_front();
    @(negedge clk);
    reset = 1'b1;

    step("ld_br", 1'b1, PC_SRC_REG, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0040_0010, 1'b0, 1'b0,
         32'h0040_0010, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("br.pc_plus_step", bus.pc_plus_step, 32'h0040_0014);
    cmp("br.branch_target", bus.branch_target, 32'h0040_000C);
    step("br_taken", 1'b1, PC_SRC_BRANCH, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0,
         32'h0040_000C, 1'b0, 1'b0, 1'b0, 1'b0);
    ld("ld_br2", 32'h0040_0010, 1'b0);
    step("br_not", 1'b1, PC_SRC_BRANCH, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0,
         32'h0040_0014, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_hold", 1'b0, PC_SRC_BRANCH, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 1'b0,
         32'h0040_0014, 1'b0, 1'b0, 1'b0, 1'b0);

    ld("ld_j", 32'h1000_0000, 1'b0);
    step("jump", 1'b1, PC_SRC_JUMP, 1'b0, 32'h0, 26'h000_0040, 32'h0, 1'b0, 1'b0,
         32'h1000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    ld("ld_wrap", 32'hFFFF_FFFC, 1'b0);
    seq("wrap", 32'h0000_0000, 1'b0);

    ld("mis_ld", 32'h0040_0006, 1'b1);
    seq("mis_seq", 32'h0040_000A, 1'b1);
    ld("mis_clr", 32'h0040_0008, 1'b0);

    // Return stack: five pushes into a four-entry stack, then five pops.
    rs("ras_ld", 1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0040_0000, 1'b0, 1'b1);
    rs("push1", 1'b1, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0010, 1'b0, !Ras);
    rs("push2", 1'b1, 1'b1, 1'b0, 32'h0040_0020, 32'h0040_0020, 1'b0, !Ras);
    rs("push3", 1'b1, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0030, 1'b0, !Ras);
    rs("push4", 1'b1, 1'b1, 1'b0, 32'h0040_0040, 32'h0040_0040, Ras, !Ras);
    rs("push5", 1'b1, 1'b1, 1'b0, 32'h0050_0000, 32'h0050_0000, Ras, !Ras);
    rs("pop1", 1'b1, 1'b0, 1'b1, 32'h0090_0000, Ras ? 32'h0040_0044 : 32'h0090_0000, 1'b0,
       !Ras);
    rs("pop2", 1'b1, 1'b0, 1'b1, 32'h0090_0000, Ras ? 32'h0040_0034 : 32'h0090_0000, 1'b0,
       !Ras);
    rs("pop3", 1'b1, 1'b0, 1'b1, 32'h0090_0000, Ras ? 32'h0040_0024 : 32'h0090_0000, 1'b0,
       !Ras);
    rs("pop4", 1'b1, 1'b0, 1'b1, 32'h0090_0000, Ras ? 32'h0040_0014 : 32'h0090_0000, 1'b0,
       1'b1);
    rs("pop_empty", 1'b1, 1'b0, 1'b1, 32'h0090_0000, 32'h0090_0000, 1'b0, 1'b1);

    // Simultaneous link+ret replaces the top; a gated cycle must leave the stack alone.
    rs("sim_ld", 1'b1, 1'b0, 1'b0, 32'h0040_00FC, 32'h0040_00FC, 1'b0, 1'b1);
    rs("sim_push", 1'b1, 1'b1, 1'b0, 32'h0040_0200, 32'h0040_0200, 1'b0, !Ras);
    rs("gated", 1'b0, 1'b1, 1'b1, 32'h0090_0000, 32'h0040_0200, 1'b0, !Ras);
    rs("link_ret", 1'b1, 1'b1, 1'b1, 32'h0090_0000, Ras ? 32'h0040_0100 : 32'h0090_0000,
       1'b0, !Ras);
    rs("pop_new", 1'b1, 1'b0, 1'b1, 32'h00A0_0000, Ras ? 32'h0040_0204 : 32'h00A0_0000, 1'b0,
       1'b1);

    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the multicycle MIPS datapath, succeeding the standalone branch-target adder. It holds the PC register and computes the sequential, branch, jump and register-indirect next-PC values. It also keeps an optional return-address stack for call/return sequences. It sits between the control FSM (PCWrite, PCSrc) and the instruction-memory address port.

## Interface
- WORD_LENGTH, 32, datapath width; must be ≥ 32
- RESET_PC, 32'h0040_0000, PC value after reset
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-stack entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- pc_write  input  1  PC load enable for this cycle (multicycle PCWrite)
- pc_src  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 register/return
- branch_cond  input  1  branch taken when 1; only meaningful with pc_src=01
- sign_ext_imm  input  WORD_LENGTH  sign-extended branch offset, in words
- jump_index  input  26  J-type instruction index
- reg_target  input  WORD_LENGTH  register operand for JR/JALR
- link  input  1  push return address (JAL/JALR)
- ret  input  1  pop return address (JR $ra)
- pc  output  WORD_LENGTH  current PC
- pc_plus_step  output  WORD_LENGTH  pc + STEP, combinational
- branch_target  output  WORD_LENGTH  pc + STEP + (sign_ext_imm << 2), combinational
- ras_full, ras_empty  output  1 each  stack status, registered
- misaligned  output  1  the last loaded PC had nonzero bits [1:0]

## Operation
- **Next PC** is selected by pc_src:
  - 00: pc_plus_step.
  - 01: branch_target if branch_cond=1, otherwise pc_plus_step.
  - 10: jump target = {pc_plus_step[WORD_LENGTH-1:28], jump_index, 2'b00}.
  - 11: stack top if ret=1 and the stack is non-empty (RAS built in), otherwise reg_target.
- **PC load:** the PC loads the next PC only when pc_write=1. Otherwise it holds.
- **Arithmetic:** all sums are modulo 2^WORD_LENGTH; wrap-around is silent. The shift by 2 discards sign_ext_imm's top two bits.
- **misaligned:** registered on every load, equal to |next_pc[1:0]. The PC still loads the unaligned value.
- **Push:** when pc_write=1 and link=1, pc_plus_step is pushed.
  - Full stack: the oldest entry is overwritten (circular buffer). The count saturates at RAS_DEPTH and ras_full stays 1.
- **Pop:** when pc_write=1, pc_src=11 and ret=1, the stack pops.
  - Empty stack: next PC = reg_target and the count stays 0.
- **Push and pop together:** next PC = old top, and that top entry is replaced by pc_plus_step. The count is unchanged.
- **Gating:** with pc_write=0, link and ret are ignored and the stack is untouched.

## Timing
- **Reset** (asynchronous, any cycle, including mid call/return): pc=RESET_PC, misaligned=0, stack count=0, ras_empty=1, ras_full=0. Stack contents are don't-care.
- **Latency:** 1 cycle. The next PC is visible on pc at the rising edge where pc_write=1.
- pc_plus_step and branch_target follow pc combinationally in the same cycle.
- ras_full and ras_empty update on the same edge as the push or pop.
- No handshake. The control FSM guarantees that link, ret and pc_src are stable while pc_write=1.

## Configuration
- **Macro:** PC_SEQUENCER_RAS_EN.
- **Defined:** the return-address stack is compiled in with the behaviour above.
- **Undefined:**
  - No stack storage exists; link and ret are ignored.
  - pc_src=11 always selects reg_target.
  - ras_empty is constant 1 and ras_full is constant 0.

## Structure
- **Package pc_seq_pkg holds:**
  - pc_src encoding constants PC_SRC_SEQ, PC_SRC_BRANCH, PC_SRC_JUMP, PC_SRC_REG;
  - default RESET_PC and STEP constants;
  - the jump-region split position (28).
- **Sub-module return_stack:**
  - parametrised by WORD_LENGTH and RAS_DEPTH;
  - top pointer, saturating count, push/pop/replace logic, full/empty flags;
  - instantiated only under PC_SEQUENCER_RAS_EN.
- Next-PC mux, adders and PC register stay in pc_sequencer.

## Test plan
- **Reset and sequential step:** release reset, then assert pc_write for 3 cycles with pc_src=00 -> pc = 0x00400000, then 0x00400004, 0x00400008, 0x0040000C. Then pulse reset low mid-cycle -> pc=0x00400000 immediately.
- **Branch:** pc=0x00400010, sign_ext_imm=0xFFFFFFFE, pc_src=01.
  - branch_cond=1 -> pc=0x0040000C.
  - branch_cond=0 -> pc=0x00400014.
  - pc_write=0 -> pc holds.
- **Jump and wrap:**
  - pc=0x10000000, jump_index=0x0000040, pc_src=10 -> pc=0x10000100.
  - pc=0xFFFFFFFC, pc_src=00 -> pc=0x00000000.
- **Misaligned:** reg_target=0x00400006, pc_src=11, ret=0 -> pc=0x00400006 and misaligned=1. Next sequential load -> pc=0x0040000A, misaligned stays 1 (bits [1:0]=10). Load reg_target=0x00400008 -> misaligned=0.
- **RAS, RAS_DEPTH=4:**
  - Five link pushes from pc=0x00400000, 0x00400010, 0x00400020, 0x00400030, 0x00400040 -> ras_full=1.
  - Four ret pops -> pc = 0x00400044, 0x00400034, 0x00400024, 0x00400014 (the first push was overwritten); ras_empty=1 after the 4th pop.
  - A fifth pop -> pc=reg_target.
- **Simultaneous link+ret:** stack top=0x00400100, pc=0x00400200, pc_src=11 -> pc=0x00400100, new top=0x00400204, count unchanged. Without PC_SEQUENCER_RAS_EN -> pc=reg_target, ras_empty=1.
